// File: rtl/sprite_pkg.sv
// Shared definitions for the circle sprite streamer.
//   mode_e       : FILLED disc or one-pixel RING
//   state_e      : streamer FSM states
//   sprite_dim   : sprite side length, 2*MAX_RADIUS+1
//   sprite_sq_w  : width that holds any squared distance inside the sprite
//   col_dx2      : elaboration-time (j-C)^2 column term
package sprite_pkg;

  typedef enum logic {
    FILLED = 1'b0,
    RING   = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam int DEFAULT_MAX_RADIUS = 63;

  function automatic int sprite_dim(input int max_radius);
    return 2 * max_radius + 1;
  endfunction

  // Largest distance is a corner: 2*MAX_RADIUS^2.
  function automatic int sprite_sq_w(input int max_radius);
    return $clog2(2 * max_radius * max_radius + 1);
  endfunction

  function automatic int col_dx2(input int j, input int centre);
    return (j - centre) * (j - centre);
  endfunction

endpackage

// File: rtl/circle_row_mask.sv
// Combinational row rasterizer for one sprite row.
// Ports:
//   dy2      in  : (i-C)^2 for the row being produced
//   r2       in  : r^2
//   rm1_2    in  : (r-1)^2 (0 when r = 0)
//   mode     in  : FILLED or RING
//   row_bits out : bit j set when pixel (i,j) lies inside the shape
// Each column adds its constant dx^2 to dy2 and compares against the
// radius bounds, so the per-pixel path is one add plus two compares.
module circle_row_mask
  import sprite_pkg::*;
#(
  parameter int MAX_RADIUS = DEFAULT_MAX_RADIUS,
  parameter int SQ_W       = sprite_sq_w(MAX_RADIUS),
  localparam int DIM       = sprite_dim(MAX_RADIUS)
) (
  input  logic [SQ_W-1:0] dy2,
  input  logic [SQ_W-1:0] r2,
  input  logic [SQ_W-1:0] rm1_2,
  input  mode_e           mode,
  output logic [DIM-1:0]  row_bits
);

  for (genvar j = 0; j < DIM; j++) begin : g_col
    localparam logic [SQ_W-1:0] DX2 = SQ_W'(col_dx2(j, MAX_RADIUS));
    logic [SQ_W-1:0] d;
    // dy2 + dx2 never exceeds 2*C^2, which SQ_W holds exactly.
    assign d           = dy2 + DX2;
    assign row_bits[j] = (d < r2) && ((mode == FILLED) || (d >= rm1_2));
  end

endmodule

// File: rtl/circle_sprite_streamer.sv
// Streams a (2*MAX_RADIUS+1)-square circle sprite mask, one row per beat.
// Ports:
//   clock, reset_L          : clock, asynchronous active-low reset
//   start, radius, mode     : new sprite request, taken only in IDLE
//   abort                   : cancel an in-progress sprite (SETUP/STREAM)
//   busy                    : high whenever not IDLE
//   row_valid/row_ready     : output row handshake
//   row_index, row_bits     : row number and its pixel mask
//   last_row                : marks row DIM-1
//   done                    : one-cycle pulse after the last row is taken
//   state_dbg               : current FSM state
//
// Handshake: a row transfers on a rising edge where row_valid & row_ready.
// While row_valid is high and row_ready is low, row_index, row_bits and
// last_row are held. row_valid only falls after a transfer, on abort, or
// on reset.
module circle_sprite_streamer
  import sprite_pkg::*;
#(
  parameter int MAX_RADIUS = DEFAULT_MAX_RADIUS,
  parameter int RAD_W      = $clog2(MAX_RADIUS + 1),
  parameter int SQ_W       = sprite_sq_w(MAX_RADIUS),
  localparam int DIM       = sprite_dim(MAX_RADIUS),
  localparam int IDX_W     = $clog2(DIM)
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic [RAD_W-1:0] radius,
  input  logic             mode,
  input  logic             abort,
  output logic             busy,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [IDX_W-1:0] row_index,
  output logic [DIM-1:0]   row_bits,
  output logic             last_row,
  output logic             done,
  output state_e           state_dbg
);

  localparam int                    C        = MAX_RADIUS;
  localparam logic [SQ_W-1:0]       C_SQ     = SQ_W'(C * C);
  localparam int                    SW       = SQ_W + 2;
  localparam logic signed [SW-1:0]  TWO_C    = SW'(2 * C);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DIM - 1);
  localparam logic [RAD_W-1:0]      RAD_MAX  = RAD_W'(MAX_RADIUS);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [SQ_W-1:0]  r2_q, r2_d;
  logic [SQ_W-1:0]  rm1_2_q, rm1_2_d;
  logic [SQ_W-1:0]  dy2_q, dy2_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIM-1:0]   bits_q, bits_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  logic [RAD_W-1:0]     rad_clamped;
  logic [SQ_W-1:0]      rad_ext;
  logic [SQ_W-1:0]      rad_m1_ext;
  logic signed [SW-1:0] dy2_step;
  logic [SQ_W-1:0]      dy2_next;
  logic [SQ_W-1:0]      mask_dy2;
  logic [DIM-1:0]       mask_bits;
  logic [IDX_W-1:0]     idx_next;
  logic                 accept;
  logic                 unused_step_hi;

  // Radius is clamped before squaring; the squares are captured with the
  // request so SETUP only has the row-mask path to cover.
  always_comb begin
    rad_clamped = (radius > RAD_MAX) ? RAD_MAX : radius;
    rad_ext     = SQ_W'(rad_clamped);
    rad_m1_ext  = (rad_clamped == '0) ? '0 : rad_ext - SQ_W'(1);
  end

  // dy^2(i+1) = dy^2(i) - 2C + 2i + 1, formed signed because the middle
  // term can dip below zero before the +2i+1 is added back.
  always_comb begin
    dy2_step = $signed({2'b00, dy2_q}) - TWO_C + $signed(SW'({idx_q, 1'b1}));
    dy2_next = dy2_step[SQ_W-1:0];
    mask_dy2 = (state_q == SETUP) ? C_SQ : dy2_next;
    idx_next = idx_q + IDX_W'(1);
  end

  // The headroom bits are zero for every row inside the sprite.
  assign unused_step_hi = ^dy2_step[SW-1:SQ_W];

  circle_row_mask #(
    .MAX_RADIUS (MAX_RADIUS),
    .SQ_W       (SQ_W)
  ) u_row_mask (
    .dy2      (mask_dy2),
    .r2       (r2_q),
    .rm1_2    (rm1_2_q),
    .mode     (mode_q),
    .row_bits (mask_bits)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    r2_d    = r2_q;
    rm1_2_d = rm1_2_q;
    dy2_d   = dy2_q;
    idx_d   = idx_q;
    bits_d  = bits_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    accept  = valid_q && row_ready;

    case (state_q)
      IDLE: begin
        // abort is meaningless here, so start always wins.
        if (start) begin
          mode_d  = mode_e'(mode);
          r2_d    = rad_ext * rad_ext;
          rm1_2_d = rad_m1_ext * rad_m1_ext;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          dy2_d   = C_SQ;
          idx_d   = '0;
          bits_d  = mask_bits;
          last_d  = (LAST_IDX == '0);
          valid_d = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (abort) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end else if (accept) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d  = idx_next;
            dy2_d  = dy2_next;
            bits_d = mask_bits;
            last_d = (idx_next == LAST_IDX);
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      mode_q  <= FILLED;
      r2_q    <= '0;
      rm1_2_q <= '0;
      dy2_q   <= '0;
      idx_q   <= '0;
      bits_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      r2_q    <= r2_d;
      rm1_2_q <= rm1_2_d;
      dy2_q   <= dy2_d;
      idx_q   <= idx_d;
      bits_q  <= bits_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign row_valid = valid_q;
  assign row_index = idx_q;
  assign row_bits  = bits_q;
  assign last_row  = last_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_circle_sprite_streamer.sv
module tb_circle_sprite_streamer;
  import sprite_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_L;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT, MAX_RADIUS = 63 ----------------
  logic         start, mode, abort, row_ready;
  logic [5:0]   radius;
  logic         busy, row_valid, last_row, done;
  logic [6:0]   row_index;
  logic [126:0] row_bits;
  state_e       state_dbg;

  circle_sprite_streamer #(.MAX_RADIUS(63)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .start     (start),
    .radius    (radius),
    .mode      (mode),
    .abort     (abort),
    .busy      (busy),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_index (row_index),
    .row_bits  (row_bits),
    .last_row  (last_row),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- DUT, MAX_RADIUS = 5 ----------------
  logic        s_start, s_mode, s_abort, s_ready;
  logic [2:0]  s_radius;
  logic        s_busy, s_valid, s_last, s_done;
  logic [3:0]  s_index;
  logic [10:0] s_bits;
  state_e      s_state;

  circle_sprite_streamer #(.MAX_RADIUS(5)) dut_small (
    .clock     (clock),
    .reset_L   (reset_L),
    .start     (s_start),
    .radius    (s_radius),
    .mode      (s_mode),
    .abort     (s_abort),
    .busy      (s_busy),
    .row_valid (s_valid),
    .row_ready (s_ready),
    .row_index (s_index),
    .row_bits  (s_bits),
    .last_row  (s_last),
    .done      (s_done),
    .state_dbg (s_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // entry = {last, index[6:0], bits[126:0]}
  logic [134:0] exp_q[$];
  logic [134:0] s_exp_q[$];
  logic [126:0] captured [0:126];
  logic [10:0]  s_captured [0:10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference pixel rule, evaluated directly from squared distances.
  function automatic logic [126:0] model_row(input int mr, input int r, input bit ring, input int i);
    logic [126:0] b;
    int rr, rm, d;
    b  = '0;
    rr = r * r;
    rm = (r == 0) ? 0 : (r - 1) * (r - 1);
    for (int j = 0; j < 2 * mr + 1; j++) begin
      d = (i - mr) * (i - mr) + (j - mr) * (j - mr);
      if (d < rr && (!ring || d >= rm)) b[j] = 1'b1;
    end
    return b;
  endfunction

  // Monitors: pop and compare on every transfer.
  always @(negedge clock) begin
    logic [134:0] e;
    if (reset_L && row_valid && row_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_row: got row %0d, expected no row", row_index);
      end else begin
        e = exp_q.pop_front();
        chk("row_index", 128'(row_index), 128'(e[133:127]));
        chk("row_bits", 128'(row_bits), 128'(e[126:0]));
        chk("last_row", 128'(last_row), 128'(e[134]));
      end
      captured[row_index] = row_bits;
    end
  end

  always @(negedge clock) begin
    logic [134:0] e;
    if (reset_L && s_valid && s_ready) begin
      if (s_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL s_unexpected_row: got row %0d, expected no row", s_index);
      end else begin
        e = s_exp_q.pop_front();
        chk("s_row_index", 128'(s_index), 128'(e[133:127]));
        chk("s_row_bits", 128'(s_bits), 128'(e[126:0]));
        chk("s_last_row", 128'(s_last), 128'(e[134]));
      end
      if (s_index < 4'd11) s_captured[s_index] = s_bits;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_sprite(input int r, input bit ring, input int nrows);
    for (int i = 0; i < nrows; i++)
      exp_q.push_back({(i == 126), 7'(i), model_row(63, r, ring, i)});
  endtask

  task automatic do_start(input int r, input bit ring, input bit with_abort, input bit chk_lat);
    @(posedge clock); #1;
    start  = 1'b1;
    radius = 6'(r);
    mode   = ring;
    abort  = with_abort;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    if (chk_lat) begin
      @(negedge clock);
      chk("setup_busy", 128'(busy), 128'(1));
      chk("setup_valid", 128'(row_valid), 128'(0));
      chk("setup_state", 128'(state_dbg), 128'(SETUP));
      @(negedge clock);
      chk("first_valid", 128'(row_valid), 128'(1));
      chk("first_index", 128'(row_index), 128'(0));
    end
  endtask

  task automatic wait_row(input int idx);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(posedge clock); #1;
      if (row_valid && row_index == 7'(idx)) found = 1'b1;
    end
    chk($sformatf("reach_row_%0d", idx), 128'(found), 128'(1));
  endtask

  task automatic wait_last(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clock);
      if (row_valid && row_ready && last_row) seen = 1'b1;
    end
    chk({tag, "_last_seen"}, 128'(seen), 128'(1));
    if (seen) begin
      @(negedge clock);
      chk({tag, "_done"}, 128'(done), 128'(1));
      chk({tag, "_busy_after"}, 128'(busy), 128'(0));
      chk({tag, "_valid_after"}, 128'(row_valid), 128'(0));
      @(negedge clock);
      chk({tag, "_done_pulse"}, 128'(done), 128'(0));
    end
    chk({tag, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_valid"}, 128'(row_valid), 128'(0));
    chk({tag, "_index"}, 128'(row_index), 128'(0));
    chk({tag, "_bits"}, 128'(row_bits), 128'(0));
    chk({tag, "_last"}, 128'(last_row), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_s_busy"}, 128'(s_busy), 128'(0));
    chk({tag, "_s_bits"}, 128'(s_bits), 128'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "simulation time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [126:0] h;
    logic [10:0]  sh;
    bit           seen;

    reset_L = 1'b0;
    start = 1'b0; radius = '0; mode = 1'b0; abort = 1'b0; row_ready = 1'b0;
    s_start = 1'b0; s_radius = '0; s_mode = 1'b0; s_abort = 1'b0; s_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_outputs("reset");
    @(posedge clock); #1;
    reset_L = 1'b1;
    @(negedge clock);
    chk_reset_outputs("post_reset");

    // radius 0, filled: every row empty
    row_ready = 1'b1;
    push_sprite(0, 1'b0, 127);
    do_start(0, 1'b0, 1'b0, 1'b1);
    wait_last("r0");

    // radius 2, filled
    push_sprite(2, 1'b0, 127);
    do_start(2, 1'b0, 1'b0, 1'b0);
    wait_last("r2f");
    h = '0; h[62] = 1'b1; h[63] = 1'b1; h[64] = 1'b1;
    chk("r2f_row62", 128'(captured[62]), 128'(h));
    chk("r2f_row63", 128'(captured[63]), 128'(h));
    chk("r2f_row64", 128'(captured[64]), 128'(h));
    chk("r2f_row61", 128'(captured[61]), 128'(0));

    // radius 2, ring: centre pixel drops out
    push_sprite(2, 1'b1, 127);
    do_start(2, 1'b1, 1'b0, 1'b0);
    wait_last("r2r");
    h = '0; h[62] = 1'b1; h[64] = 1'b1;
    chk("r2r_row63", 128'(captured[63]), 128'(h));
    h[63] = 1'b1;
    chk("r2r_row62", 128'(captured[62]), 128'(h));

    // radius 63, filled: widest row spans columns 1..125; row 0 sits on r^2
    push_sprite(63, 1'b0, 127);
    do_start(63, 1'b0, 1'b0, 1'b1);
    wait_last("r63");
    h = '0;
    for (int j = 1; j <= 125; j++) h[j] = 1'b1;
    chk("r63_row63", 128'(captured[63]), 128'(h));
    chk("r63_row0", 128'(captured[0]), 128'(0));
    h = '0;
    for (int j = 52; j <= 74; j++) h[j] = 1'b1;
    chk("r63_row1", 128'(captured[1]), 128'(h));

    // backpressure on row 10
    push_sprite(60, 1'b0, 127);
    do_start(60, 1'b0, 1'b0, 1'b0);
    wait_row(10);
    row_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_index", 128'(row_index), 128'(10));
      chk("bp_bits", 128'(row_bits), 128'(model_row(63, 60, 1'b0, 10)));
      chk("bp_valid", 128'(row_valid), 128'(1));
    end
    @(posedge clock); #1;
    row_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("bp_next_index", 128'(row_index), 128'(11));
    wait_last("bp");

    // start while busy is ignored, then abort on row 40
    push_sprite(45, 1'b1, 40);
    do_start(45, 1'b1, 1'b0, 1'b0);
    wait_row(5);
    start = 1'b1; radius = 6'd3; mode = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    wait_row(40);
    abort = 1'b1;
    row_ready = 1'b0;
    @(posedge clock); #1;
    abort = 1'b0;
    row_ready = 1'b1;
    @(negedge clock);
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_valid", 128'(row_valid), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_state", 128'(state_dbg), 128'(IDLE));
    chk("abort_queue_empty", 128'(exp_q.size()), 128'(0));

    // abort alone in IDLE does nothing
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    chk("idle_abort_busy", 128'(busy), 128'(0));
    chk("idle_abort_done", 128'(done), 128'(0));

    // fresh sprite with start and abort together: start wins
    push_sprite(7, 1'b0, 127);
    do_start(7, 1'b0, 1'b1, 1'b1);
    wait_last("fresh");

    // small instance: radius 7 clamps to 5
    s_ready = 1'b1;
    for (int i = 0; i < 11; i++)
      s_exp_q.push_back({(i == 10), 7'(i), model_row(5, 5, 1'b0, i)});
    @(posedge clock); #1;
    s_start = 1'b1; s_radius = 3'd7; s_mode = 1'b0;
    @(posedge clock); #1;
    s_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clock);
      if (s_valid && s_ready && s_last) seen = 1'b1;
    end
    chk("small_last_seen", 128'(seen), 128'(1));
    @(negedge clock);
    chk("small_done", 128'(s_done), 128'(1));
    chk("small_busy_after", 128'(s_busy), 128'(0));
    chk("small_queue_empty", 128'(s_exp_q.size()), 128'(0));
    sh = 11'b01111111110;
    chk("small_row5", 128'(s_captured[5]), 128'(sh));
    chk("small_row0", 128'(s_captured[0]), 128'(0));

    // reset in the middle of a sprite
    row_ready = 1'b0;
    do_start(30, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    chk("pre_reset_valid", 128'(row_valid), 128'(1));
    #2;
    reset_L = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(posedge clock); #1;
    reset_L = 1'b1;
    @(negedge clock);
    chk("post_mid_reset_busy", 128'(busy), 128'(0));
    chk("post_mid_reset_done", 128'(done), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
